// File: rtl/core_msg_receiver.sv
// Core-side receiver for the scheduler message bus: filters the flagged message
// stream for this core, captures its r0 init value and instruction words, and starts the pipeline.
module core_msg_receiver #(
    parameter int CORE_ID    = 0,
    parameter int CORE_NUM   = 16,
    parameter int INSTR_SIZE = 16,
    parameter int IBUF_DEPTH = 256,
    parameter int R0_WORDS   = 13,
    parameter logic [INSTR_SIZE-1:0] END_INSTR = '1,
    localparam int AW = $clog2(IBUF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [INSTR_SIZE-1:0] mess_to_core,
    input  logic                  core_mask_loading,
    input  logic                  r0_mask_loading,
    input  logic                  r0_loading,
    input  logic                  instr_loading,
    input  logic                  exec_done,
    input  logic [AW-1:0]         ibuf_rd_addr,
    output logic                  core_reading,
    output logic                  core_ready,
    output logic                  exec_start,
    output logic [INSTR_SIZE-1:0] ibuf_rd_data,
    output logic [AW:0]           instr_count,
    output logic [INSTR_SIZE-1:0] r0_value,
    output logic                  r0_valid,
    output logic                  overflow,
    output logic                  protocol_err
);

    localparam int RANK_W = $clog2(CORE_NUM + R0_WORDS + 1);
    localparam logic [AW:0]       DEPTH_C = (AW+1)'(IBUF_DEPTH);
    localparam logic [AW:0]       CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [3:0]        R0_MAX  = 4'(R0_WORDS);
    localparam logic [RANK_W-1:0] R0_LIM  = RANK_W'(R0_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_R0MASK,
        S_R0DATA,
        S_INSTR,
        S_EXEC
    } state_t;

    state_t state, state_next;

    logic [INSTR_SIZE-1:0] ibuf [IBUF_DEPTH];
    // Only bits up to our own index matter: lower bits give the rank, our bit gives selection.
    logic [CORE_ID:0]      r0_sel_mask;
    logic [3:0]            r0_cnt;
    logic [RANK_W-1:0]     rank;

    logic act_cm, act_rm, act_r0, act_in, multi, own, is_end;
    logic task_start, mask_take, r0_take, instr_take, err_set;
    logic buf_room, r0_hit, ibuf_we;

    // Lower flags are masked by higher ones so only one action is taken per cycle.
    assign act_cm = core_mask_loading;
    assign act_rm = r0_mask_loading & ~core_mask_loading;
    assign act_r0 = r0_loading & ~core_mask_loading & ~r0_mask_loading;
    assign act_in = instr_loading & ~core_mask_loading & ~r0_mask_loading & ~r0_loading;
    assign multi  = (core_mask_loading & (r0_mask_loading | r0_loading | instr_loading)) |
                    (r0_mask_loading & (r0_loading | instr_loading)) |
                    (r0_loading & instr_loading);
    assign own    = mess_to_core[CORE_ID];
    assign is_end = (mess_to_core == END_INSTR);

    always_comb begin
        rank = '0;
        for (int i = 0; i < CORE_ID; i++)
            rank = rank + RANK_W'(r0_sel_mask[i]);
    end

    assign r0_hit   = r0_sel_mask[CORE_ID] && (rank == RANK_W'(r0_cnt)) && (rank < R0_LIM);
    assign buf_room = (instr_count < DEPTH_C);
    assign ibuf_we  = reset_n && instr_take && buf_room;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        task_start = 1'b0;
        mask_take  = 1'b0;
        r0_take    = 1'b0;
        instr_take = 1'b0;
        err_set    = multi;
        case (state)
            S_IDLE: begin
                if (act_cm && own) begin
                    state_next = S_R0MASK;
                    task_start = 1'b1;
                end
            end
            S_R0MASK: begin
                if (act_cm) begin
                    state_next = own ? S_R0MASK : S_IDLE;
                    task_start = own;
                end else if (act_rm) begin
                    mask_take  = 1'b1;
                    state_next = S_R0DATA;
                end else if (act_r0 || act_in) begin
                    err_set = 1'b1;
                end
            end
            S_R0DATA: begin
                if (act_cm) begin
                    state_next = own ? S_R0MASK : S_IDLE;
                    task_start = own;
                end else if (act_rm) begin
                    err_set = 1'b1;
                end else if (act_r0) begin
                    r0_take = 1'b1;
                end else if (act_in) begin
                    instr_take = 1'b1;
                    state_next = S_INSTR;
                end
            end
            S_INSTR: begin
                // A new core mask here means the previous task never sent END_INSTR.
                if (act_cm) begin
                    err_set    = 1'b1;
                    state_next = own ? S_R0MASK : S_IDLE;
                    task_start = own;
                end else if (act_rm || act_r0) begin
                    err_set = 1'b1;
                end else if (act_in) begin
                    instr_take = 1'b1;
                end
            end
            S_EXEC: begin
                if (act_cm && own) err_set = 1'b1;
                if (exec_done) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (instr_take && is_end) state_next = S_EXEC;
    end

    assign core_reading = reset_n && (state != S_EXEC);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            core_ready   <= 1'b0;
            exec_start   <= 1'b0;
            instr_count  <= '0;
            r0_value     <= '0;
            r0_valid     <= 1'b0;
            overflow     <= 1'b0;
            protocol_err <= 1'b0;
            r0_sel_mask  <= '0;
            r0_cnt       <= '0;
        end else begin
            core_ready <= (state_next == S_IDLE);
            exec_start <= instr_take && is_end;
            if (err_set) protocol_err <= 1'b1;
            if (task_start) begin
                instr_count <= '0;
                r0_cnt      <= '0;
                r0_valid    <= 1'b0;
                overflow    <= 1'b0;
            end
            if (mask_take) r0_sel_mask <= mess_to_core[CORE_ID:0];
            if (r0_take) begin
                if (r0_cnt < R0_MAX) r0_cnt <= r0_cnt + 4'd1;
                if (r0_hit) begin
                    r0_value <= mess_to_core;
                    r0_valid <= 1'b1;
                end
            end
            if (instr_take) begin
                if (buf_room) instr_count <= instr_count + CNT_ONE;
                else          overflow    <= 1'b1;
            end
        end
    end

    // Plain memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ibuf_we) ibuf[instr_count[AW-1:0]] <= mess_to_core;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) ibuf_rd_data <= '0;
        else          ibuf_rd_data <= ibuf[ibuf_rd_addr];
    end

endmodule

// File: tb/tb_core_msg_receiver.sv
// Bench for core_msg_receiver (CORE_ID=5, 8-word buffer): directed vector table,
// hand sequences for reset/overflow/priority, then random traffic against a task-level model.
module tb_core_msg_receiver;

    localparam int ID    = 5;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] mess_to_core;
    logic        core_mask_loading, r0_mask_loading, r0_loading, instr_loading;
    logic        exec_done;
    logic [2:0]  ibuf_rd_addr;
    logic        core_reading, core_ready, exec_start;
    logic [15:0] ibuf_rd_data;
    logic [3:0]  instr_count;
    logic [15:0] r0_value;
    logic        r0_valid, overflow, protocol_err;

    int checks = 0;
    int errors = 0;

    core_msg_receiver #(.CORE_ID(ID), .CORE_NUM(16), .INSTR_SIZE(16), .IBUF_DEPTH(DEPTH),
                        .R0_WORDS(13), .END_INSTR(16'hFFFF)) dut (
        .clk(clk), .reset_n(reset_n), .mess_to_core(mess_to_core),
        .core_mask_loading(core_mask_loading), .r0_mask_loading(r0_mask_loading),
        .r0_loading(r0_loading), .instr_loading(instr_loading), .exec_done(exec_done),
        .ibuf_rd_addr(ibuf_rd_addr), .core_reading(core_reading), .core_ready(core_ready),
        .exec_start(exec_start), .ibuf_rd_data(ibuf_rd_data), .instr_count(instr_count),
        .r0_value(r0_value), .r0_valid(r0_valid), .overflow(overflow), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    // Task-level model: buffer as an array plus word counts, r0 picked by rank from the word sequence.
    typedef enum {M_IDLE, M_MASK, M_DATA, M_INSTR, M_EXEC} mph_t;
    mph_t        m_ph = M_IDLE;
    int          m_cnt = 0, m_r0n = 0;
    bit          m_ovf, m_err, m_start, m_ready, m_r0v, m_rd_known;
    logic [15:0] m_r0 = '0, m_mask = '0, m_rd = '0;
    logic [15:0] m_ibuf [DEPTH];
    bit          m_known [DEPTH];

    task automatic m_begin();
        m_ph = M_MASK; m_cnt = 0; m_r0n = 0; m_r0v = 0; m_ovf = 0;
    endtask

    task automatic m_instr(input logic [15:0] w, inout bit go);
        m_ph = M_INSTR;
        if (m_cnt < DEPTH) begin
            m_ibuf[m_cnt] = w; m_known[m_cnt] = 1; m_cnt++;
        end else m_ovf = 1;
        if (w == 16'hFFFF) go = 1;
    endtask

    task automatic model_step(input logic rn, input logic [3:0] f, input logic [15:0] w,
                              input logic d, input logic [2:0] a);
        mph_t prev;
        bit sel, go;
        int rank;
        if (!rn) begin
            m_ph = M_IDLE; m_cnt = 0; m_r0n = 0; m_ovf = 0; m_err = 0; m_start = 0;
            m_ready = 0; m_r0v = 0; m_r0 = '0; m_mask = '0; m_rd = '0; m_rd_known = 1;
            return;
        end
        m_rd_known = m_known[a];
        m_rd = m_ibuf[a];
        prev = m_ph; sel = w[ID]; go = 0;
        if ($countones(f) > 1) m_err = 1;
        if (prev == M_EXEC) begin
            if (f[3] && sel) m_err = 1;
            if (d) m_ph = M_IDLE;
        end else if (f[3]) begin
            if (prev == M_INSTR) m_err = 1;
            if (sel) m_begin();
            else m_ph = M_IDLE;
        end else if (f[2]) begin
            if (prev == M_MASK) begin m_mask = w; m_ph = M_DATA; end
            else if (prev != M_IDLE) m_err = 1;
        end else if (f[1]) begin
            if (prev == M_DATA) begin
                rank = $countones(m_mask & ((16'h1 << ID) - 16'h1));
                if (m_mask[ID] && m_r0n == rank && rank < 13) begin m_r0 = w; m_r0v = 1; end
                m_r0n++;
            end else if (prev != M_IDLE) m_err = 1;
        end else if (f[0]) begin
            if (prev == M_DATA || prev == M_INSTR) m_instr(w, go);
            else if (prev == M_MASK) m_err = 1;
        end
        if (go) m_ph = M_EXEC;
        m_start = go;
        m_ready = (m_ph == M_IDLE);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rn, input logic [3:0] f, input logic [15:0] w,
                         input logic d, input logic [2:0] a);
        @(negedge clk);
        reset_n = rn;
        {core_mask_loading, r0_mask_loading, r0_loading, instr_loading} = f;
        mess_to_core = w; exec_done = d; ibuf_rd_addr = a;
        model_step(rn, f, w, d, a);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        chk("rnd reading", core_reading, reset_n && (m_ph != M_EXEC));
        chk("rnd ready", core_ready, m_ready);
        chk("rnd start", exec_start, m_start);
        chk("rnd count", instr_count, m_cnt);
        chk("rnd r0", r0_value, m_r0);
        chk("rnd r0v", r0_valid, m_r0v);
        chk("rnd ovf", overflow, m_ovf);
        chk("rnd err", protocol_err, m_err);
        if (m_rd_known) chk("rnd rd", ibuf_rd_data, m_rd);
    endtask

    typedef struct {
        logic rn; logic [3:0] f; logic [15:0] w; logic d;
        logic st, rd, rdy; logic [3:0] cnt; logic [15:0] r0; logic r0v, ovf, err;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(logic rn, logic [3:0] f, logic [15:0] w, logic d, logic st,
                               logic rd, logic rdy, logic [3:0] cnt, logic [15:0] r0,
                               logic r0v, logic ovf, logic err);
        vec_t x;
        x.rn = rn; x.f = f; x.w = w; x.d = d; x.st = st; x.rd = rd; x.rdy = rdy;
        x.cnt = cnt; x.r0 = r0; x.r0v = r0v; x.ovf = ovf; x.err = err;
        return x;
    endfunction

    initial begin
        logic [3:0]  f;
        logic [15:0] w;
        int r;

        reset_n = 0; mess_to_core = '0; exec_done = 0; ibuf_rd_addr = '0;
        {core_mask_loading, r0_mask_loading, r0_loading, instr_loading} = 4'b0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;

        // basic task
        tbl.push_back(v(1, 4'b1000, 16'h0020, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(v(1, 4'b0100, 16'h0020, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(v(1, 4'b0010, 16'h00AB, 0, 0, 1, 0, 0, 16'h00AB, 1, 0, 0));
        tbl.push_back(v(1, 4'b0001, 16'h1111, 0, 0, 1, 0, 1, 16'h00AB, 1, 0, 0));
        tbl.push_back(v(1, 4'b0001, 16'h2222, 0, 0, 1, 0, 2, 16'h00AB, 1, 0, 0));
        tbl.push_back(v(1, 4'b0001, 16'hFFFF, 0, 1, 0, 0, 3, 16'h00AB, 1, 0, 0));
        tbl.push_back(v(1, 4'b0000, 16'h0000, 0, 0, 0, 0, 3, 16'h00AB, 1, 0, 0));
        tbl.push_back(v(1, 4'b0000, 16'h0000, 1, 0, 1, 1, 3, 16'h00AB, 1, 0, 0));
        // task for another core
        tbl.push_back(v(1, 4'b1000, 16'h0004, 0, 0, 1, 1, 3, 16'h00AB, 1, 0, 0));
        tbl.push_back(v(1, 4'b0100, 16'h0004, 0, 0, 1, 1, 3, 16'h00AB, 1, 0, 0));
        tbl.push_back(v(1, 4'b0010, 16'h1234, 0, 0, 1, 1, 3, 16'h00AB, 1, 0, 0));
        tbl.push_back(v(1, 4'b0001, 16'h5555, 0, 0, 1, 1, 3, 16'h00AB, 1, 0, 0));
        tbl.push_back(v(1, 4'b0001, 16'hFFFF, 0, 0, 1, 1, 3, 16'h00AB, 1, 0, 0));
        // rank 2 (mask bits 0,2,5)
        tbl.push_back(v(1, 4'b1000, 16'h0020, 0, 0, 1, 0, 0, 16'h00AB, 0, 0, 0));
        tbl.push_back(v(1, 4'b0100, 16'h0025, 0, 0, 1, 0, 0, 16'h00AB, 0, 0, 0));
        tbl.push_back(v(1, 4'b0010, 16'h000A, 0, 0, 1, 0, 0, 16'h00AB, 0, 0, 0));
        tbl.push_back(v(1, 4'b0010, 16'h000B, 0, 0, 1, 0, 0, 16'h00AB, 0, 0, 0));
        tbl.push_back(v(1, 4'b0010, 16'h000C, 0, 0, 1, 0, 0, 16'h000C, 1, 0, 0));
        tbl.push_back(v(1, 4'b0010, 16'h000D, 0, 0, 1, 0, 0, 16'h000C, 1, 0, 0));
        tbl.push_back(v(1, 4'b0001, 16'hFFFF, 0, 1, 0, 0, 1, 16'h000C, 1, 0, 0));
        tbl.push_back(v(1, 4'b0000, 16'h0000, 1, 0, 1, 1, 1, 16'h000C, 1, 0, 0));
        // own bit clear in r0 mask
        tbl.push_back(v(1, 4'b1000, 16'h0020, 0, 0, 1, 0, 0, 16'h000C, 0, 0, 0));
        tbl.push_back(v(1, 4'b0100, 16'h0015, 0, 0, 1, 0, 0, 16'h000C, 0, 0, 0));
        tbl.push_back(v(1, 4'b0010, 16'h0111, 0, 0, 1, 0, 0, 16'h000C, 0, 0, 0));
        tbl.push_back(v(1, 4'b0010, 16'h0222, 0, 0, 1, 0, 0, 16'h000C, 0, 0, 0));
        tbl.push_back(v(1, 4'b0010, 16'h0333, 0, 0, 1, 0, 0, 16'h000C, 0, 0, 0));
        tbl.push_back(v(1, 4'b0001, 16'hFFFF, 0, 1, 0, 0, 1, 16'h000C, 0, 0, 0));
        tbl.push_back(v(1, 4'b0000, 16'h0000, 1, 0, 1, 1, 1, 16'h000C, 0, 0, 0));

        // reset held 3 cycles, then release
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'b0000, 16'h0000, 0, 3'd0);
            chk("rst reading", core_reading, 0);
            chk("rst ready", core_ready, 0);
            chk("rst start", exec_start, 0);
            chk("rst err", protocol_err, 0);
        end
        @(negedge clk);
        reset_n = 1;
        #1;
        chk("rel reading", core_reading, 1);
        chk("rel ready", core_ready, 0);
        model_step(1, 4'b0000, 16'h0000, 0, 3'd0);
        @(posedge clk);
        #1;
        chk("rel ready edge", core_ready, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].rn, tbl[i].f, tbl[i].w, tbl[i].d, 3'd0);
            chk($sformatf("vec%0d start", i), exec_start, tbl[i].st);
            chk($sformatf("vec%0d reading", i), core_reading, tbl[i].rd);
            chk($sformatf("vec%0d ready", i), core_ready, tbl[i].rdy);
            chk($sformatf("vec%0d count", i), instr_count, tbl[i].cnt);
            chk($sformatf("vec%0d r0", i), r0_value, tbl[i].r0);
            chk($sformatf("vec%0d r0v", i), r0_valid, tbl[i].r0v);
            chk($sformatf("vec%0d ovf", i), overflow, tbl[i].ovf);
            chk($sformatf("vec%0d err", i), protocol_err, tbl[i].err);
        end

        drive(1, 4'b0000, 16'h0000, 0, 3'd1);
        chk("ibuf[1]", ibuf_rd_data, 16'h2222);
        drive(1, 4'b0000, 16'h0000, 0, 3'd2);
        chk("ibuf[2]", ibuf_rd_data, 16'hFFFF);
        drive(1, 4'b0000, 16'h0000, 0, 3'd0);
        chk("ibuf[0]", ibuf_rd_data, 16'hFFFF);

        // overflow: 10 words into an 8-word buffer, then END
        drive(1, 4'b1000, 16'h0020, 0, 3'd0);
        drive(1, 4'b0100, 16'h0020, 0, 3'd0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 4'b0001, 16'(i + 16'h0100), 0, 3'd0);
            chk("ovf count", instr_count, (i < DEPTH) ? i + 1 : DEPTH);
            chk("ovf flag", overflow, (i >= DEPTH) ? 1 : 0);
        end
        drive(1, 4'b0001, 16'hFFFF, 0, 3'd7);
        chk("ovf end count", instr_count, DEPTH);
        chk("ovf end flag", overflow, 1);
        chk("ovf end start", exec_start, 1);
        chk("ovf ibuf[7]", ibuf_rd_data, 16'h0107);
        drive(1, 4'b0000, 16'h0000, 0, 3'd0);
        chk("ovf start pulse", exec_start, 0);
        drive(1, 4'b0000, 16'h0000, 1, 3'd0);

        // core mask and instr in the same cycle: mask wins, error flagged
        drive(1, 4'b1001, 16'h0020, 0, 3'd0);
        chk("prio err", protocol_err, 1);
        chk("prio ready", core_ready, 0);
        chk("prio count", instr_count, 0);
        chk("prio ovf", overflow, 0);

        // reset mid-instruction stream
        drive(1, 4'b0100, 16'h0020, 0, 3'd0);
        drive(1, 4'b0001, 16'h1234, 0, 3'd0);
        chk("mid count", instr_count, 1);
        drive(0, 4'b0000, 16'h0000, 0, 3'd0);
        chk("mid rst err", protocol_err, 0);
        chk("mid rst start", exec_start, 0);
        chk("mid rst count", instr_count, 0);
        drive(1, 4'b0000, 16'h0000, 0, 3'd0);
        chk("mid idle ready", core_ready, 1);
        drive(1, 4'b0001, 16'hFFFF, 0, 3'd0);
        chk("mid no start", exec_start, 0);
        chk("mid no count", instr_count, 0);

        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 99);
            w = 16'($urandom);
            f = 4'b0000;
            if (r < 7) begin
                f = 4'b1000;
                w[ID] = ($urandom_range(0, 9) < 6);
            end else if (r < 17) begin
                f = 4'b0100;
            end else if (r < 40) begin
                f = 4'b0010;
            end else if (r < 75) begin
                f = 4'b0001;
                if ($urandom_range(0, 5) == 0) w = 16'hFFFF;
            end else if (r < 78) begin
                f = 4'($urandom);
            end
            drive(($urandom_range(0, 299) != 0), f, w, ($urandom_range(0, 7) == 0),
                  3'($urandom));
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
